// File: rtl/dm_stage_param.sv
// Parametrised data-memory pipeline stage: single-port array with self-clearing init,
// 1-cycle read/pass-through, and sticky illegal-access detection.
module dm_stage_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel_dm,
    input  logic              err_clr,
    output logic [DATA_W-1:0] ans_dm,
    output logic              dm_ready,
    output logic              dm_err
);

    // Index width only needs to cover DEPTH words; never wider than the address field.
    localparam int IDX_W = ($clog2(DEPTH) < ADDR_W) ? $clog2(DEPTH) : ADDR_W;
    localparam logic [DATA_W:0] DEPTH_L = (DATA_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   ans_q, ans_d;
    logic                dm_ready_q, dm_ready_d;
    logic                dm_err_q, dm_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                in_range;
    logic                legal;
    logic                illegal;
    logic [IDX_W-1:0]    idx;

    // Range check uses the full execute value, so high bits beyond the index count.
    assign in_range = ({1'b0, ans_ex} < DEPTH_L);
    assign idx      = ans_ex[IDX_W-1:0];
    assign legal    = mem_en_ex && (state_q == RUN) && in_range;
    assign illegal  = mem_en_ex && !legal;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_d       = rd_q;
        ans_d      = ans_ex;
        dm_ready_d = dm_ready_q;
        dm_err_d   = dm_err_q;
        mem_we     = 1'b0;
        mem_wa     = idx;
        mem_wd     = DM_data;

        if (state_q == INIT) begin
            mem_we = 1'b1;
            mem_wa = ptr_q;
            mem_wd = '0;
            ptr_d  = ptr_q + IDX_W'(1);
            if (ptr_q == LAST_IDX) begin
                state_d    = RUN;
                dm_ready_d = 1'b1;
            end
        end

        if (legal) begin
            if (mem_rw_ex) begin
                mem_we = 1'b1;
            end else begin
                rd_d = mem_q[idx];
            end
        end else if (illegal && !mem_rw_ex) begin
            rd_d = '0;
        end

        // A new illegal access outranks a simultaneous clear.
        if (illegal) begin
            dm_err_d = 1'b1;
        end else if (err_clr) begin
            dm_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            ptr_q      <= '0;
            rd_q       <= '0;
            ans_q      <= '0;
            dm_ready_q <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            ans_q      <= ans_d;
            dm_ready_q <= dm_ready_d;
            dm_err_q   <= dm_err_d;
        end
    end

    // Array has no reset; the INIT pass clears it after every reset release.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign ans_dm   = mem_mux_sel_dm ? rd_q : ans_q;
    assign dm_ready = dm_ready_q;
    assign dm_err   = dm_err_q;

endmodule

// File: tb/tb_dm_stage_param.sv
// Directed bench for dm_stage_param with DATA_W=8, ADDR_W=8, DEPTH=16.
module tb_dm_stage_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ans_ex;
    logic [7:0] DM_data;
    logic       mem_en_ex;
    logic       mem_rw_ex;
    logic       mem_mux_sel_dm;
    logic       err_clr;
    logic [7:0] ans_dm;
    logic       dm_ready;
    logic       dm_err;

    int n_checks = 0;
    int n_fail   = 0;

    dm_stage_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .ans_ex         (ans_ex),
        .DM_data        (DM_data),
        .mem_en_ex      (mem_en_ex),
        .mem_rw_ex      (mem_rw_ex),
        .mem_mux_sel_dm (mem_mux_sel_dm),
        .err_clr        (err_clr),
        .ans_dm         (ans_dm),
        .dm_ready       (dm_ready),
        .dm_err         (dm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_en_ex = 1'b0;
        mem_rw_ex = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic access(input logic rw, input logic [7:0] addr, input logic [7:0] data);
        mem_en_ex = 1'b1;
        mem_rw_ex = rw;
        ans_ex    = addr;
        DM_data   = data;
    endtask

    initial begin
        reset = 1'b0;
        ans_ex = 8'h00;
        DM_data = 8'h00;
        mem_mux_sel_dm = 1'b0;
        idle();
        #1;
        check("rst_ans_dm", ans_dm, 8'h00);
        check("rst_ready", dm_ready, 1'b0);
        check("rst_err", dm_err, 1'b0);
        tick();
        tick();
        reset = 1'b1;

        // Init sequence: ready only after the 16th edge.
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("init_ready_e%0d", i), dm_ready, (i == 16) ? 1'b1 : 1'b0);
            check($sformatf("init_ans_e%0d", i), ans_dm, 8'h00);
        end

        mem_mux_sel_dm = 1'b1;
        for (int a = 0; a < 16; a++) begin
            access(1'b0, 8'(a), 8'h00);
            tick();
            check($sformatf("clear_rd_%0d", a), ans_dm, 8'h00);
        end
        check("clear_err", dm_err, 1'b0);

        // Write then read-back in the next cycle.
        access(1'b1, 8'h03, 8'hFF);
        tick();
        check("wr_holds_rd", ans_dm, 8'h00);
        access(1'b0, 8'h03, 8'h00);
        tick();
        check("rd_after_wr", ans_dm, 8'hFF);
        mem_mux_sel_dm = 1'b0;
        #1;
        check("pass_thru", ans_dm, 8'h03);
        mem_mux_sel_dm = 1'b1;

        // Disabled cycle holds rd_q while ans_q follows ans_ex.
        idle();
        ans_ex = 8'h07;
        tick();
        check("en0_hold_rd", ans_dm, 8'hFF);
        mem_mux_sel_dm = 1'b0;
        #1;
        check("en0_pass", ans_dm, 8'h07);
        mem_mux_sel_dm = 1'b1;

        // Out-of-range write is dropped (would alias to index 0).
        access(1'b1, 8'h10, 8'hAA);
        tick();
        check("oor_wr_err", dm_err, 1'b1);
        access(1'b0, 8'h00, 8'h00);
        tick();
        check("oor_wr_dropped", ans_dm, 8'h00);
        access(1'b0, 8'h03, 8'h00);
        tick();
        check("rd3_again", ans_dm, 8'hFF);
        access(1'b0, 8'h20, 8'h00);
        tick();
        check("oor_rd_zero", ans_dm, 8'h00);
        check("oor_rd_err", dm_err, 1'b1);

        // Error clear, and set-wins-over-clear.
        idle();
        err_clr = 1'b1;
        tick();
        check("err_clr", dm_err, 1'b0);
        access(1'b1, 8'h12, 8'h99);
        err_clr = 1'b1;
        tick();
        check("err_set_wins", dm_err, 1'b1);
        idle();
        tick();
        check("err_sticky", dm_err, 1'b1);

        // Mid-operation reset.
        access(1'b1, 8'h05, 8'h55);
        tick();
        access(1'b0, 8'h05, 8'h00);
        tick();
        check("rd5_before_rst", ans_dm, 8'h55);
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ans", ans_dm, 8'h00);
        check("midrst_ready", dm_ready, 1'b0);
        check("midrst_err", dm_err, 1'b0);
        #1;
        reset = 1'b1;
        tick();
        for (int i = 2; i <= 16; i++) begin
            if (i == 4) begin
                access(1'b1, 8'h00, 8'h77);
            end else if (i == 6) begin
                access(1'b0, 8'h05, 8'h00);
            end else begin
                idle();
            end
            tick();
            if (i == 4) begin
                check("init_wr_err", dm_err, 1'b1);
            end
            if (i == 6) begin
                check("init_rd_zero", ans_dm, 8'h00);
            end
            check($sformatf("reinit_ready_e%0d", i), dm_ready, (i == 16) ? 1'b1 : 1'b0);
        end
        access(1'b0, 8'h05, 8'h00);
        tick();
        check("rd5_after_reinit", ans_dm, 8'h00);
        access(1'b0, 8'h00, 8'h00);
        tick();
        check("init_wr_suppressed", ans_dm, 8'h00);
        idle();
        err_clr = 1'b1;
        tick();
        check("final_err_clr", dm_err, 1'b0);
        check("final_ready", dm_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
